// File: rtl/g_macro_pkg.sv
// Shared constants and state encoding for the dual-channel debouncer.
package g_macro_pkg;

  // Default number of synchronizer flops per channel (legal 2..4).
  localparam int G_SYNC_STAGES_DEF = 2;
  // Default number of consecutive stable synced cycles before the output moves.
  localparam int G_DB_COUNT_DEF    = 50000;
  // Default debounce counter width.
  localparam int G_CNT_W_DEF       = 16;

  // Per-channel debounce states. The msb doubles as "debounced level is low".
  typedef enum logic [1:0] {
    STABLE_HI = 2'b00,
    CHK_LO    = 2'b01,
    STABLE_LO = 2'b10,
    CHK_HI    = 2'b11
  } dbnc_state_t;

endpackage : g_macro_pkg

// File: rtl/g_dbnc1.sv
// Single debounce channel: synchronizer, four-state debounce FSM with a
// saturating-by-construction stability counter, and registered edge pulses.
module g_dbnc1
  import g_macro_pkg::*;
#(
  parameter int SYNC_STAGES = G_SYNC_STAGES_DEF,
  parameter int DB_COUNT    = G_DB_COUNT_DEF,
  parameter int CNT_W       = G_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,      // synchronous, active-high
  input  logic raw_n,    // raw active-low input, asynchronous to clk
  output logic q_n,      // debounced active-low level
  output logic fall,     // one-cycle pulse on q_n 1->0
  output logic rise,     // one-cycle pulse on q_n 0->1
  output logic [CNT_W-1:0] cnt
);

  // The counter value at which the next stable cycle completes the debounce:
  // the cycle that enters CHK already counts as stable cycle number one.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  dbnc_state_t            state;

  assign synced = sync[SYNC_STAGES-1];

  // Synchronizer chain; reset to the released (high) level so no spurious
  // assert is seen while the chain refills after reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    if (rst) sync <= '1;
    else     sync <= {sync[SYNC_STAGES-2:0], raw_n};
  end

  // Debounce FSM with registered level and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE_HI;
      cnt   <= '0;
      q_n   <= 1'b1;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle and are only raised on the
      // transition edge, which guarantees a single-cycle width.
      fall <= 1'b0;
      rise <= 1'b0;
      unique case (state)
        STABLE_HI: begin
          if (!synced) begin
            if (DB_COUNT == 1) begin
              state <= STABLE_LO;
              cnt   <= '0;
              q_n   <= 1'b0;
              fall  <= 1'b1;
            end else begin
              state <= CHK_LO;
              cnt   <= CNT_ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        CHK_LO: begin
          if (synced) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= STABLE_LO;
            cnt   <= '0;
            q_n   <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_LO: begin
          if (synced) begin
            if (DB_COUNT == 1) begin
              state <= STABLE_HI;
              cnt   <= '0;
              q_n   <= 1'b1;
              rise  <= 1'b1;
            end else begin
              state <= CHK_HI;
              cnt   <= CNT_ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        CHK_HI: begin
          if (!synced) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= STABLE_HI;
            cnt   <= '0;
            q_n   <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule : g_dbnc1

// File: rtl/g_2dbnc.sv
// Dual-channel debouncer: two independent g_dbnc1 channels, no shared logic.
module g_2dbnc
  import g_macro_pkg::*;
#(
  parameter int SYNC_STAGES = G_SYNC_STAGES_DEF,
  parameter int DB_COUNT    = G_DB_COUNT_DEF,
  parameter int CNT_W       = G_CNT_W_DEF
) (
  input  logic CK,
  input  logic CD,
  input  logic RAN,
  input  logic RBN,
  output logic QAN,
  output logic QBN,
  output logic FALLA,
  output logic FALLB,
  output logic RISEA,
  output logic RISEB
);

  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  g_dbnc1 #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_COUNT    (DB_COUNT),
    .CNT_W       (CNT_W)
  ) u_ch_a (
    .clk   (CK),
    .rst   (CD),
    .raw_n (RAN),
    .q_n   (QAN),
    .fall  (FALLA),
    .rise  (RISEA),
    .cnt   (cnt_a)
  );

  g_dbnc1 #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_COUNT    (DB_COUNT),
    .CNT_W       (CNT_W)
  ) u_ch_b (
    .clk   (CK),
    .rst   (CD),
    .raw_n (RBN),
    .q_n   (QBN),
    .fall  (FALLB),
    .rise  (RISEB),
    .cnt   (cnt_b)
  );

endmodule : g_2dbnc

// File: tb/tb_g_2dbnc.sv
// Directed bench for g_2dbnc: main instance at DB_COUNT=4, second at DB_COUNT=1.
module tb_g_2dbnc;

  logic CK = 1'b0;
  logic CD;
  logic RAN, RBN;
  logic QAN, QBN, FALLA, FALLB, RISEA, RISEB;
  logic RAN1, RBN1;
  logic QAN1, QBN1, FALLA1, FALLB1, RISEA1, RISEB1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CK = ~CK;

  g_2dbnc #(.SYNC_STAGES(2), .DB_COUNT(4), .CNT_W(16)) dut (
    .CK(CK), .CD(CD), .RAN(RAN), .RBN(RBN),
    .QAN(QAN), .QBN(QBN), .FALLA(FALLA), .FALLB(FALLB),
    .RISEA(RISEA), .RISEB(RISEB)
  );

  g_2dbnc #(.SYNC_STAGES(2), .DB_COUNT(1), .CNT_W(16)) dut1 (
    .CK(CK), .CD(CD), .RAN(RAN1), .RBN(RBN1),
    .QAN(QAN1), .QBN(QBN1), .FALLA(FALLA1), .FALLB(FALLB1),
    .RISEA(RISEA1), .RISEB(RISEB1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Main-instance outputs packed as {QAN,QBN,FALLA,FALLB,RISEA,RISEB}.
  function automatic logic [5:0] outs();
    return {QAN, QBN, FALLA, FALLB, RISEA, RISEB};
  endfunction

  initial begin
    CD = 1'b1; RAN = 1'b1; RBN = 1'b1; RAN1 = 1'b1; RBN1 = 1'b1;
    repeat (3) tick();
    check("reset_outs", 32'(outs()), 32'b110000);
    check("reset_outs_db1", 32'({QAN1, QBN1, FALLA1, FALLB1, RISEA1, RISEB1}), 32'b110000);
    check("reset_cnt", 32'(dut.u_ch_a.cnt), 32'd0);

    // Idle high for 20 cycles: no movement, no pulses.
    CD = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("idle_%0d", i), 32'(outs()), 32'b110000);
    end

    // Glitch: raw low for 3 sampling edges, then high.
    RAN = 1'b0;
    repeat (3) tick();
    RAN = 1'b1;
    for (int i = 4; i <= 10; i++) begin
      tick();
      check($sformatf("glitch_outs_e%0d", i), 32'(outs()), 32'b110000);
      if (i == 5) check("glitch_cnt_peak", 32'(dut.u_ch_a.cnt), 32'd3);
    end
    check("glitch_cnt_back", 32'(dut.u_ch_a.cnt), 32'd0);

    // Held assert on A: QAN falls on edge 6 with a single FALLA.
    RAN = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("a_fall_wait_e%0d", i), 32'(outs()), 32'b110000);
    end
    tick();
    check("a_fall_e6", 32'(outs()), 32'b011000);
    tick();
    check("a_fall_e7", 32'(outs()), 32'b010000);

    // Held assert on B.
    RBN = 1'b0;
    repeat (5) tick();
    check("b_fall_e5", 32'(outs()), 32'b010000);
    tick();
    check("b_fall_e6", 32'(outs()), 32'b000100);
    repeat (2) tick();
    check("b_low_quiet", 32'(outs()), 32'b000000);

    // Simultaneous release: both RISE pulses on the same edge.
    RAN = 1'b1; RBN = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("rel_wait_e%0d", i), 32'(outs()), 32'b000000);
    end
    tick();
    check("rel_both_e6", 32'(outs()), 32'b110011);
    tick();
    check("rel_both_e7", 32'(outs()), 32'b110000);

    // Reset mid-debounce: count abandoned, restart from scratch.
    RAN = 1'b0;
    repeat (4) tick();
    check("mid_cnt2", 32'(dut.u_ch_a.cnt), 32'd2);
    CD = 1'b1;
    tick();
    check("mid_rst_outs", 32'(outs()), 32'b110000);
    check("mid_rst_cnt", 32'(dut.u_ch_a.cnt), 32'd0);
    CD = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("restart_wait_e%0d", i), 32'(outs()), 32'b110000);
    end
    tick();
    check("restart_fall_e6", 32'(outs()), 32'b011000);

    // Reset while QAN is low: no RISE around or after reset.
    tick();
    CD = 1'b1; RAN = 1'b1;
    tick();
    check("rst_low_outs", 32'(outs()), 32'b110000);
    CD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("post_rst_quiet_%0d", i), 32'(outs()), 32'b110000);
    end

    // DB_COUNT=1 instance: QBN follows 3 edges after sampling.
    RBN1 = 1'b0;
    repeat (2) tick();
    check("db1_wait_e2", 32'({QBN1, FALLB1}), 32'b10);
    tick();
    check("db1_fall_e3", 32'({QBN1, FALLB1}), 32'b01);
    tick();
    check("db1_fall_e4", 32'({QBN1, FALLB1}), 32'b00);
    RBN1 = 1'b1;
    repeat (2) tick();
    check("db1_rel_e2", 32'({QBN1, RISEB1}), 32'b00);
    tick();
    check("db1_rel_e3", 32'({QBN1, RISEB1}), 32'b11);
    tick();
    check("db1_rel_e4", 32'({QBN1, RISEB1, QAN1, FALLA1}), 32'b1010);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_g_2dbnc

// File: doc/g_2dbnc.md
G_2DBNC -- requirements
Module: g_2dbnc

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per channel; legal range 2..4.
REQ-002 Parameter DB_COUNT, default 50000, consecutive stable cycles required before the output changes; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 16, debounce counter width in bits.
REQ-004 CK  input  1  sole clock; all flops on the rising edge.
REQ-005 CD  input  1  reset, synchronous, active-high.
REQ-006 RAN  input  1  raw channel A, active-low, asynchronous to CK (e.g. push-button).
REQ-007 RBN  input  1  raw channel B, active-low, asynchronous to CK.
REQ-008 QAN  output  1  debounced channel A, active-low; feeds a downstream inverted-input OR stage.
REQ-009 QBN  output  1  debounced channel B, active-low.
REQ-010 FALLA/FALLB  output  1 each  one-cycle pulse when QAN/QBN go 1->0 (assert).
REQ-011 RISEA/RISEB  output  1 each  one-cycle pulse when QAN/QBN go 0->1 (release).

Function
REQ-012 Each channel SHALL pass its raw input through SYNC_STAGES flops before any other use; no raw input SHALL reach the control logic or outputs directly.
REQ-013 Each channel SHALL run an independent FSM: STABLE_HI, CHK_LO, STABLE_LO, CHK_HI.
REQ-014 STABLE_HI: synced=0 -> CHK_LO, counter=1; else stay, counter=0.
REQ-015 CHK_LO: synced=1 -> STABLE_HI, counter=0; synced=0 and counter=DB_COUNT -> STABLE_LO, counter=0; otherwise counter+1.
REQ-016 STABLE_LO and CHK_HI SHALL mirror REQ-014/015 with polarities swapped.
REQ-017 With DB_COUNT=1, the FSM SHALL go directly from STABLE_HI to STABLE_LO (and back) on the first cycle the synced value differs; no CHK cycle SHALL be required.
REQ-018 QxN SHALL be registered, 1 in STABLE_HI/CHK_LO and 0 in STABLE_LO/CHK_HI.
REQ-019 Latency: a raw step held stable SHALL change QxN exactly SYNC_STAGES+DB_COUNT rising edges after the first edge that samples the new raw value.
REQ-020 Any glitch shorter than DB_COUNT synced cycles SHALL leave QxN unchanged and reset the counter.
REQ-021 FALLx/RISEx SHALL be registered and asserted in the same cycle QxN first shows its new value, for exactly one cycle.
REQ-022 The counter SHALL never exceed DB_COUNT and SHALL never wrap.
REQ-023 Channels A and B SHALL be fully independent; simultaneous transitions on both SHALL produce simultaneous, correct pulses.

Reset
REQ-024 While CD=1 at a rising edge, all sync flops SHALL load 1, FSMs STABLE_HI, counters 0, QAN=QBN=1, all pulse outputs 0.
REQ-025 Reset asserted mid-debounce SHALL abandon the count with no pulse; the first cycle after reset SHALL emit no RISE pulse even if QxN was 0 before reset.

Structure
REQ-026 State encodings (2-bit) and the default DB_COUNT/SYNC_STAGES constants SHALL live in shared package g_macro_pkg.
REQ-027 One sub-module g_dbnc1 (single channel: synchronizer, FSM, counter, pulse logic) SHALL be instantiated twice; the top SHALL contain no other logic.

Verification (SYNC_STAGES=2, DB_COUNT=4 unless stated)
REQ-028 Reset, then RAN=RBN=1 for 20 cycles -> QAN=QBN=1, no pulses.
REQ-029 RAN 1->0 held -> QAN=0 exactly 6 edges after first sampling edge, FALLA=1 that cycle only; QBN stays 1.
REQ-030 RAN low for 3 synced cycles then high -> QAN stays 1, no FALLA; counter returns to 0.
REQ-031 RAN and RBN both released together after debounced-low -> RISEA and RISEB pulse in the same cycle, 6 edges later.
REQ-032 CD asserted at count 2 of CHK_LO -> QAN=1, no pulse; debounce after release of CD restarts from zero (6 more edges).
REQ-033 DB_COUNT=1: RBN 1->0 -> QBN=0 after 3 edges, FALLB single pulse.
